// File: rtl/freq_detect_sequencer.sv
// freq_detect_sequencer: runs the audio-command measurement cycle while the rover is stopped.
// The cycle is a settle interval, then three counting windows on mic edge pulses. The three
// counts are classified into a steering nibble, which is offered to the drive logic over a
// valid/ack handshake. The block also owns the reverse-mode flag.
// Optional feature macro: FREQ_SEQ_LOCKOUT_EN. When it is defined, a lockout counter limits
// how often band D may toggle reverse. When it is not defined, every band-D match toggles.
module freq_detect_sequencer #(
  parameter logic [27:0] PERIOD  = 28'd10000000,
  parameter logic [27:0] SETTLE  = 28'd1000000,
  parameter logic [31:0] LOCKOUT = 32'd50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       mic_rise,
  input  logic [7:0] IP_sensors,
  input  logic       cmd_ack,
  output logic       cmd_valid,
  output logic [3:0] virtual_IPsensors,
  output logic       reverse,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETTLE   = 3'd1,
    S_WIN0     = 3'd2,
    S_WIN1     = 3'd3,
    S_WIN2     = 3'd4,
    S_CLASSIFY = 3'd5,
    S_HOLD     = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [27:0] cyc_q, cyc_d;
  logic [27:0] c0_q, c1_q, c2_q;
  logic [27:0] c0_d, c1_d, c2_d;
  logic [3:0]  cmd_q, cmd_d;
  logic        valid_q, valid_d;
  logic        rev_q, rev_d;
  logic        lockFree;
  logic        loadLock;
  logic        bandA, bandB, bandC, bandD;

  // True when a count lies inside the inclusive band [lo, hi]
  function automatic logic inBand(input logic [27:0] c, input logic [27:0] lo,
                                  input logic [27:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

`ifdef FREQ_SEQ_LOCKOUT_EN
  logic [31:0] lock_q, lock_d;

  // Lockout counter: reloaded on an accepted band-D toggle, otherwise counts down to zero
  always_comb begin
    lock_d = lock_q;
    if (loadLock) begin
      lock_d = LOCKOUT;
    end else if (lock_q != 32'd0) begin
      lock_d = lock_q - 32'd1;
    end
  end

  // Lockout counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_q <= 32'd0;
    end else begin
      lock_q <= lock_d;
    end
  end

  assign lockFree = (lock_q == 32'd0);
`else
  // Band D is never locked out in this build. LOCKOUT stays in the parameter list so that
  // both builds are instantiated in the same way.
  assign lockFree = 1'b1 | (LOCKOUT == 32'd0);
`endif

  // Next-state logic, including the abort path when start drops during measurement
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (start) state_d = S_SETTLE;
      S_SETTLE:   if (!start) state_d = S_IDLE;
                  else if (cyc_q == SETTLE - 28'd1) state_d = S_WIN0;
      S_WIN0:     if (!start) state_d = S_IDLE;
                  else if (cyc_q == PERIOD - 28'd1) state_d = S_WIN1;
      S_WIN1:     if (!start) state_d = S_IDLE;
                  else if (cyc_q == PERIOD - 28'd1) state_d = S_WIN2;
      S_WIN2:     if (!start) state_d = S_IDLE;
                  else if (cyc_q == PERIOD - 28'd1) state_d = S_CLASSIFY;
      S_CLASSIFY: state_d = S_HOLD;
      S_HOLD:     if (cmd_ack && valid_q) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // The shared cycle counter restarts on every state change and only runs in timed states
  always_comb begin
    cyc_d = cyc_q + 28'd1;
    if (state_d != state_q || state_q == S_IDLE || state_q == S_HOLD) begin
      cyc_d = 28'd0;
    end
  end

  // Edge counters: cleared on entry to settle, each one counts only in its own window, saturating
  always_comb begin
    c0_d = c0_q;
    c1_d = c1_q;
    c2_d = c2_q;
    if (state_d == S_SETTLE && state_q != S_SETTLE) begin
      c0_d = 28'd0;
      c1_d = 28'd0;
      c2_d = 28'd0;
    end else if (mic_rise) begin
      if (state_q == S_WIN0 && c0_q != '1) c0_d = c0_q + 28'd1;
      if (state_q == S_WIN1 && c1_q != '1) c1_d = c1_q + 28'd1;
      if (state_q == S_WIN2 && c2_q != '1) c2_d = c2_q + 28'd1;
    end
  end

  // Classification of the three counts into a command, the reverse flag and the handshake
  always_comb begin
    bandA    = inBand(c0_q, 28'd46, 28'd59) && inBand(c1_q, 28'd46, 28'd59) &&
               inBand(c2_q, 28'd46, 28'd59);
    bandB    = inBand(c0_q, 28'd86, 28'd119) && inBand(c1_q, 28'd86, 28'd119) &&
               inBand(c2_q, 28'd86, 28'd119);
    bandC    = inBand(c0_q, 28'd181, 28'd219) && inBand(c1_q, 28'd181, 28'd219) &&
               inBand(c2_q, 28'd181, 28'd219);
    bandD    = inBand(c0_q, 28'd281, 28'd319) && inBand(c1_q, 28'd281, 28'd319) &&
               inBand(c2_q, 28'd281, 28'd319);
    cmd_d    = cmd_q;
    rev_d    = rev_q;
    valid_d  = valid_q;
    loadLock = 1'b0;
    if (state_q == S_CLASSIFY) begin
      valid_d = 1'b1;
      if (bandA) begin
        cmd_d = rev_q ? 4'b1001 : 4'b0110;
      end else if (bandB) begin
        cmd_d = rev_q ? 4'b0001 : 4'b1000;
      end else if (bandC) begin
        cmd_d = rev_q ? 4'b1000 : 4'b0001;
      end else if (bandD && lockFree) begin
        rev_d    = ~rev_q;
        loadLock = 1'b1;
        cmd_d    = rev_d ? IP_sensors[7:4] : IP_sensors[3:0];
      end else begin
        cmd_d = rev_q ? IP_sensors[7:4] : IP_sensors[3:0];
      end
    end else if (state_q == S_HOLD && cmd_ack && valid_q) begin
      valid_d = 1'b0;
    end
  end

  // State, counter and command registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cyc_q   <= 28'd0;
      c0_q    <= 28'd0;
      c1_q    <= 28'd0;
      c2_q    <= 28'd0;
      cmd_q   <= 4'b0000;
      valid_q <= 1'b0;
      rev_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      cmd_q   <= cmd_d;
      valid_q <= valid_d;
      rev_q   <= rev_d;
    end
  end

  assign cmd_valid         = valid_q;
  assign virtual_IPsensors = cmd_q;
  assign reverse           = rev_q;
  assign busy              = (state_q != S_IDLE);
  assign state             = state_q;

endmodule

// File: doc/freq_detect_sequencer.md
# freq_detect_sequencer

Controller that sequences the audio-command measurement cycle for the rover while it is stopped. It runs a settle interval and three back-to-back counting windows on synchronized microphone edge pulses, classifies the three counts into a steering command, and hands the command to the drive logic over a valid/ack handshake. It also owns the reverse-mode flag and its anti-chatter lockout. It sits between the mic edge synchronizer and the motor/IP-sensor mux.

## Interface
- `PERIOD`, 28'd10000000: length of each counting window, in clock cycles.
- `SETTLE`, 28'd1000000: settle cycles after `start` before the first window.
- `LOCKOUT`, 32'd50000000: minimum number of cycles between reverse toggles.

- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: level; rover stopped and detection requested.
- `mic_rise` in 1: one-cycle pulse per mic rising edge, already synchronized to `clock`.
- `IP_sensors` in 8: live sensor bus; [3:0] forward set, [7:4] reverse set.
- `cmd_ack` in 1: consumer accepts the command.
- `cmd_valid` out 1: a command is held on `virtual_IPsensors`.
- `virtual_IPsensors` out 4: command nibble.
- `reverse` out 1: reverse mode flag.
- `busy` out 1: high in every state except IDLE.
- `state` out 3: current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, SETTLE=1, WIN0=2, WIN1=3, WIN2=4, CLASSIFY=5, HOLD=6.
- State transitions:
  - IDLE→SETTLE when `start`=1.
  - SETTLE→WIN0 after `SETTLE` cycles.
  - WINn→next state after `PERIOD` cycles.
  - WIN2→CLASSIFY.
  - CLASSIFY→HOLD always.
  - HOLD→IDLE on `cmd_ack`.
- A single shared 28-bit cycle counter is cleared on every state entry.
- Three 28-bit edge counters `c0`, `c1`, `c2` count `mic_rise` pulses in WIN0, WIN1 and WIN2 respectively.
  - Counters saturate at all-ones.
  - Counters are cleared on entry to SETTLE.
- Bands (inclusive). A band matches only when all three counts fall inside it:
  - A: 46..59
  - B: 86..119
  - C: 181..219
  - D: 281..319
- Command chosen in CLASSIFY, shown as fwd/rev value (selected by `reverse`):
  - A: 0110/1001.
  - B: 1000/0001.
  - C: 0001/1000.
  - D with lockout count = 0: toggle `reverse`, load the lockout counter with `LOCKOUT`, output the `IP_sensors` nibble for the new mode.
  - D with lockout count ≠ 0: no toggle; output the `IP_sensors` nibble for the current mode.
  - No band: `IP_sensors[3:0]` if `reverse`=0, else `IP_sensors[7:4]`.
- Lockout counter: 32 bits. Decrements every cycle while nonzero, in every state.
- Abort: `start`=0 in SETTLE/WIN0/WIN1/WIN2 → IDLE on the next edge. No command is issued; `reverse` is unchanged.
- `start` is ignored in CLASSIFY and HOLD.

## Timing
- Reset values:
  - `cmd_valid`=0, `virtual_IPsensors`=4'b0000, `reverse`=0, `busy`=0, `state`=0.
  - All counters=0.
- `start` high at edge t → `state`=SETTLE and `busy`=1 after edge t.
- Window boundaries: WIN0 begins `SETTLE` cycles after SETTLE entry. Each window spans exactly `PERIOD` cycles.
- A `mic_rise` is counted in the state sampled on that edge. Pulses in SETTLE, CLASSIFY, HOLD and IDLE are ignored.
- CLASSIFY lasts one cycle. The command, `reverse` and `cmd_valid`=1 are all registered on the edge leaving CLASSIFY.
- Handshake: the transfer occurs on an edge where `cmd_valid`=1 and `cmd_ack`=1.
  - `cmd_valid` drops and `state`=IDLE after that edge.
  - `virtual_IPsensors` holds its last value until the next CLASSIFY.
- `cmd_ack` while `cmd_valid`=0 has no effect.
- Latency from `start` to `cmd_valid`: `SETTLE` + 3×`PERIOD` + 1 cycles.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). Operation resumes from IDLE after release.

## Configuration
- `FREQ_SEQ_LOCKOUT_EN`
  - Defined: lockout counter present; behaviour as above.
  - Undefined: counter removed; band D toggles `reverse` on every match.

## Test plan
Bench parameters: `PERIOD`=2000, `SETTLE`=10, `LOCKOUT`=20000.

- Reset, then `start`=1 with 50 pulses per window → `cmd_valid`=1 at cycle 6011 after `start`, `virtual_IPsensors`=0110. Ack → IDLE.
- 100 pulses per window, `reverse`=0 → 1000. Repeat with 200 pulses per window → 0001.
- 300 pulses per window, `IP_sensors`=8'hA5 → `reverse`=1, `virtual_IPsensors`=1010. A second band-D cycle run immediately afterwards → `reverse` stays 1, output 1010. After `LOCKOUT` cycles, band D → `reverse`=0, output 0101.
- 50/50/100 pulses across the three windows (no band) with `reverse`=0 and `IP_sensors`=8'h3C → output 1100.
- `start` dropped mid-WIN1 → IDLE on the next edge, no `cmd_valid`. `reset` pulsed in HOLD → `cmd_valid`=0 and `state`=0 immediately.
- Build without `FREQ_SEQ_LOCKOUT_EN`: two consecutive band-D cycles → `reverse` 0→1→0.
